// File: rtl/codec_unit_pkg.sv
// Shared types and constants for the CODEC register access path:
// FSM state encoding, SSM2603 register addresses and the sample-rate lookup.
package codec_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACC  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_EVAL      = 3'd4,
        ST_FINISH    = 3'd5
    } arb_state_t;

    localparam logic [6:0] CODEC_R8_SAMPLING = 7'h08;
    localparam logic [6:0] CODEC_R9_ACTIVE   = 7'h09;

    function automatic logic sr_valid(input logic [2:0] freq);
        return (freq <= 3'd4);
    endfunction

    // R8 values assume a 12.288 MHz MCLK in normal mode
    function automatic logic [8:0] sr_lut(input logic [2:0] freq);
        logic [8:0] val;
        case (freq)
            3'd0:    val = 9'h000;
            3'd1:    val = 9'h020;
            3'd2:    val = 9'h018;
            3'd3:    val = 9'h00C;
            3'd4:    val = 9'h01C;
            default: val = 9'h000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/codec_access_arbiter_if.sv
// Register port toward controller_unit. The arbiter is the master; the
// controller (or a model of it) is the slave.
interface codec_access_arbiter_if;
    logic       ctrl_wr_en;
    logic       ctrl_rd_en;
    logic [7:0] ctrl_reg_addr;
    logic [8:0] ctrl_data_in;
    logic       ctrl_busy;
    logic       ctrl_missed_ack;
    logic [8:0] ctrl_data_out;
    logic       ctrl_data_out_valid;

    modport master (
        output ctrl_wr_en, ctrl_rd_en, ctrl_reg_addr, ctrl_data_in,
        input  ctrl_busy, ctrl_missed_ack, ctrl_data_out, ctrl_data_out_valid
    );

    modport slave (
        input  ctrl_wr_en, ctrl_rd_en, ctrl_reg_addr, ctrl_data_in,
        output ctrl_busy, ctrl_missed_ack, ctrl_data_out, ctrl_data_out_valid
    );
endinterface

// File: rtl/codec_access_engine.sv
// Executes one CODEC register access at a time: issue pulse, busy handshake,
// NACK retry, busy-rise timeout and read-data capture.
module codec_access_engine
    import codec_unit_pkg::*;
#(
    parameter int MAX_RETRY    = 3,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       start_rd,
    input  logic [6:0] start_addr,
    input  logic [8:0] start_data,
    output logic       eng_idle,
    output logic       eng_finish,
    output logic       eng_error,
    output logic [8:0] eng_rdata,
    codec_access_arbiter_if.master ctrl
);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int TMO_W   = $clog2(BUSY_TIMEOUT);

    arb_state_t         state_r;
    logic [RETRY_W-1:0] retry_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               nack_r;
    logic               rd_r;
    logic               err_r;
    logic               wr_en_r;
    logic               rd_en_r;
    logic [6:0]         addr_r;
    logic [8:0]         data_r;
    logic [8:0]         rdata_r;

    assign eng_idle           = (state_r == ST_IDLE);
    assign eng_finish         = (state_r == ST_FINISH);
    assign eng_error          = err_r;
    assign eng_rdata          = rdata_r;
    assign ctrl.ctrl_wr_en    = wr_en_r;
    assign ctrl.ctrl_rd_en    = rd_en_r;
    assign ctrl.ctrl_reg_addr = {1'b0, addr_r};
    assign ctrl.ctrl_data_in  = data_r;

    // Access FSM; the issue pulse is raised on entry to ISSUE so it is high during ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            retry_r <= {RETRY_W{1'b0}};
            tmo_r   <= {TMO_W{1'b0}};
            nack_r  <= 1'b0;
            rd_r    <= 1'b0;
            err_r   <= 1'b0;
            wr_en_r <= 1'b0;
            rd_en_r <= 1'b0;
            addr_r  <= 7'h00;
            data_r  <= 9'h000;
            rdata_r <= 9'h000;
        end else begin
            wr_en_r <= 1'b0;
            rd_en_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        addr_r  <= start_addr;
                        data_r  <= start_data;
                        rd_r    <= start_rd;
                        retry_r <= {RETRY_W{1'b0}};
                        err_r   <= 1'b0;
                        wr_en_r <= ~start_rd;
                        rd_en_r <= start_rd;
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    nack_r  <= ctrl.ctrl_missed_ack;
                    tmo_r   <= {TMO_W{1'b0}};
                    state_r <= ST_WAIT_ACC;
                end
                ST_WAIT_ACC: begin
                    nack_r <= nack_r | ctrl.ctrl_missed_ack;
                    if (ctrl.ctrl_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (tmo_r == TMO_W'(BUSY_TIMEOUT - 1)) begin
                        err_r   <= 1'b1;
                        state_r <= ST_FINISH;
                    end else begin
                        tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_WAIT_DONE: begin
                    nack_r <= nack_r | ctrl.ctrl_missed_ack;
                    if (ctrl.ctrl_data_out_valid && rd_r) begin
                        rdata_r <= ctrl.ctrl_data_out;
                    end
                    if (!ctrl.ctrl_busy) begin
                        state_r <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (nack_r && (retry_r < RETRY_W'(MAX_RETRY))) begin
                        retry_r <= retry_r + {{(RETRY_W-1){1'b0}}, 1'b1};
                        wr_en_r <= ~rd_r;
                        rd_en_r <= rd_r;
                        state_r <= ST_ISSUE;
                    end else begin
                        err_r   <= nack_r;
                        state_r <= ST_FINISH;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/codec_access_arbiter.sv
// Shares the CODEC register port between software accesses and the
// three-write sample-rate config sequence (config has priority and is atomic).
module codec_access_arbiter
    import codec_unit_pkg::*;
#(
    parameter int MAX_RETRY    = 3,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic       board_clk,
    input  logic       board_resetn,
    input  logic       ctrl_init_done,
    input  logic       sw_wr_req,
    input  logic       sw_rd_req,
    input  logic [6:0] sw_addr,
    input  logic [8:0] sw_wdata,
    output logic       sw_done,
    output logic       sw_error,
    output logic [8:0] sw_rdata,
    input  logic       apply_config,
    input  logic [2:0] frequency,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_error,
    codec_access_arbiter_if.master ctrl
);
    logic       eng_start_s, eng_rd_s, eng_idle_s, eng_finish_s, eng_error_s;
    logic [6:0] eng_addr_s;
    logic [8:0] eng_data_s, eng_rdata_s;
    logic       cfg_launch_s, cfg_step_s, sw_launch_s;

    logic       cfg_pend_r, cfg_active_r, cfg_done_r, cfg_err_r;
    logic [2:0] pend_freq_r, run_freq_r;
    logic [1:0] step_r;
    logic       sw_active_r, sw_lock_r, sw_done_r, sw_err_r;
    logic [8:0] sw_rdata_r;

    assign sw_done   = sw_done_r;
    assign sw_error  = sw_err_r;
    assign sw_rdata  = sw_rdata_r;
    assign cfg_done  = cfg_done_r;
    assign cfg_error = cfg_err_r;
    assign cfg_busy  = cfg_pend_r | cfg_active_r;

    // Chooses the next access: pending config step, new config, then software
    always_comb begin
        eng_start_s  = 1'b0;
        eng_rd_s     = 1'b0;
        eng_addr_s   = sw_addr;
        eng_data_s   = sw_wdata;
        cfg_launch_s = 1'b0;
        cfg_step_s   = 1'b0;
        sw_launch_s  = 1'b0;
        if (eng_finish_s && cfg_active_r && (step_r != 2'd2) && !eng_error_s) begin
            eng_start_s = 1'b1;
            cfg_step_s  = 1'b1;
            if (step_r == 2'd0) begin
                eng_addr_s = CODEC_R8_SAMPLING;
                eng_data_s = sr_lut(run_freq_r);
            end else begin
                eng_addr_s = CODEC_R9_ACTIVE;
                eng_data_s = 9'h001;
            end
        end else if (eng_idle_s && ctrl_init_done && cfg_pend_r && !cfg_active_r) begin
            cfg_launch_s = 1'b1;
            eng_start_s  = sr_valid(pend_freq_r);
            eng_addr_s   = CODEC_R9_ACTIVE;
            eng_data_s   = 9'h000;
        end else if (eng_idle_s && ctrl_init_done && !cfg_active_r && !sw_active_r &&
                     !sw_lock_r && (sw_wr_req || sw_rd_req)) begin
            sw_launch_s = 1'b1;
            eng_start_s = 1'b1;
            eng_rd_s    = ~sw_wr_req;
        end else begin
            eng_start_s = 1'b0;
        end
    end

    // Config request latch, step counter and completion pulses
    always_ff @(posedge board_clk or negedge board_resetn) begin
        if (!board_resetn) begin
            cfg_pend_r   <= 1'b0;
            cfg_active_r <= 1'b0;
            cfg_done_r   <= 1'b0;
            cfg_err_r    <= 1'b0;
            pend_freq_r  <= 3'd0;
            run_freq_r   <= 3'd0;
            step_r       <= 2'd0;
            sw_active_r  <= 1'b0;
            sw_lock_r    <= 1'b0;
            sw_done_r    <= 1'b0;
            sw_err_r     <= 1'b0;
            sw_rdata_r   <= 9'h000;
        end else begin
            cfg_done_r <= 1'b0;
            sw_done_r  <= 1'b0;
            if (cfg_launch_s) begin
                cfg_pend_r   <= 1'b0;
                run_freq_r   <= pend_freq_r;
                cfg_active_r <= sr_valid(pend_freq_r);
                step_r       <= 2'd0;
            end
            // A bad frequency with nothing queued is answered on the next cycle
            if (apply_config) begin
                if (!sr_valid(frequency) && !cfg_pend_r && !cfg_active_r) begin
                    cfg_done_r <= 1'b1;
                    cfg_err_r  <= 1'b1;
                end else begin
                    cfg_pend_r  <= 1'b1;
                    pend_freq_r <= frequency;
                    cfg_err_r   <= 1'b0;
                end
            end
            if (cfg_launch_s && !sr_valid(pend_freq_r)) begin
                cfg_done_r <= 1'b1;
                cfg_err_r  <= 1'b1;
            end
            if (cfg_step_s) begin
                step_r <= step_r + 2'd1;
            end
            if (eng_finish_s && cfg_active_r && !cfg_step_s) begin
                cfg_active_r <= 1'b0;
                cfg_done_r   <= 1'b1;
                cfg_err_r    <= eng_error_s;
            end
            // The lock keeps a still-held request from re-issuing after its sw_done
            if (eng_finish_s && sw_active_r) begin
                sw_active_r <= 1'b0;
                sw_done_r   <= 1'b1;
                sw_err_r    <= eng_error_s;
                sw_rdata_r  <= eng_rdata_s;
                sw_lock_r   <= 1'b1;
            end else if (!sw_wr_req && !sw_rd_req) begin
                sw_lock_r <= 1'b0;
            end
            if (sw_launch_s) begin
                sw_active_r <= 1'b1;
            end
        end
    end

    codec_access_engine #(
        .MAX_RETRY    (MAX_RETRY),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) u_engine (
        .clk        (board_clk),
        .rst_n      (board_resetn),
        .start      (eng_start_s),
        .start_rd   (eng_rd_s),
        .start_addr (eng_addr_s),
        .start_data (eng_data_s),
        .eng_idle   (eng_idle_s),
        .eng_finish (eng_finish_s),
        .eng_error  (eng_error_s),
        .eng_rdata  (eng_rdata_s),
        .ctrl       (ctrl)
    );

endmodule
